// File: rtl/core_config_pkg.sv
// Shared core configuration: default widths, ALU command encoding and the alu1
// FSM/shifter enums.
package core_config_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;

    // Encodings 10..15 are unused and reported through i_error.
    typedef enum logic [3:0] {
        c_ADD  = 4'd0,
        c_SUB  = 4'd1,
        c_AND  = 4'd2,
        c_OR   = 4'd3,
        c_XOR  = 4'd4,
        c_SLL  = 4'd5,
        c_SRL  = 4'd6,
        c_SRA  = 4'd7,
        c_SLT  = 4'd8,
        c_SLTU = 4'd9
    } alu_commands_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu1_state_t;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shift_dir_t;

    function automatic logic is_shift(input alu_commands_t c);
        return c inside {c_SLL, c_SRL, c_SRA};
    endfunction

    function automatic logic is_supported(input alu_commands_t c);
        return c inside {c_ADD, c_SUB, c_AND, c_OR, c_XOR, c_SLL, c_SRL, c_SRA, c_SLT, c_SLTU};
    endfunction

endpackage

// File: rtl/alu1_shifter.sv
// Iterative shifter: moves up to SHIFT_STEP bits per cycle until the remaining
// count is exhausted. data_next/last let the owner capture the final value early.
module alu1_shifter
    import core_config_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [XLEN-1:0]          data_in,
    input  logic [$clog2(XLEN)-1:0]  shamt,
    input  shift_dir_t               dir,
    output logic [XLEN-1:0]          data_next,
    output logic                     last,
    output logic                     done
);

    localparam int SW = $clog2(XLEN);
    localparam logic [SW:0] STEP = (SW+1)'(SHIFT_STEP);

    logic [XLEN-1:0] data;
    logic [SW-1:0]   remaining;
    shift_dir_t      dir_q;
    logic [SW:0]     step;

    always_comb begin
        step = ({1'b0, remaining} < STEP) ? {1'b0, remaining} : STEP;
        unique case (dir_q)
            SH_LL:   data_next = data << step;
            // The current MSB is still the original sign, so >>> fills correctly.
            SH_RA:   data_next = $unsigned($signed(data) >>> step);
            default: data_next = data >> step;
        endcase
    end

    assign done = (remaining == '0);
    assign last = !done && ({1'b0, remaining} <= STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= '0;
            remaining <= '0;
            dir_q     <= SH_LL;
        end else if (load) begin
            data      <= data_in;
            remaining <= shamt;
            dir_q     <= dir;
        end else if (!done) begin
            data      <= data_next;
            remaining <= remaining - step[SW-1:0];
        end
    end

endmodule

// File: rtl/alu1.sv
// Parametrised integer ALU with iterative shifts; each result is held in DONE
// until commit acknowledges it with clear.
module alu1
    import core_config_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int SHIFT_STEP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  alu_commands_t         cmd,
    input  logic [XLEN-1:0]       arg0,
    input  logic [XLEN-1:0]       arg1,
    input  logic [REG_ADDR_W-1:0] i_rd,
    output logic                  busy,
    output logic                  valid,
    output logic [XLEN-1:0]       res,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic                  o_error,
    output logic                  i_error,
    input  logic                  clear
);

    localparam int SW = $clog2(XLEN);

    alu1_state_t     state, state_next;
    logic            accept, supported, shift_op, long_shift;
    logic [SW-1:0]   shamt;
    logic [XLEN:0]   alu_out;
    shift_dir_t      dir;
    logic [XLEN-1:0] sh_next;
    logic            sh_last, sh_done;

    assign supported  = is_supported(cmd);
    assign shift_op   = is_shift(cmd);
    assign shamt      = arg1[SW-1:0];
    assign accept     = (state == IDLE) && start && supported;
    assign long_shift = shift_op && (shamt != '0);

    always_comb begin
        alu_out = '0;
        dir     = SH_LL;
        unique case (cmd)
            c_ADD:  alu_out = {1'b0, arg0} + {1'b0, arg1};
            c_SUB:  alu_out = {1'b0, arg0} - {1'b0, arg1};
            c_AND:  alu_out = {1'b0, arg0 & arg1};
            c_OR:   alu_out = {1'b0, arg0 | arg1};
            c_XOR:  alu_out = {1'b0, arg0 ^ arg1};
            c_SLT:  alu_out = {{XLEN{1'b0}}, $signed(arg0) < $signed(arg1)};
            c_SLTU: alu_out = {{XLEN{1'b0}}, arg0 < arg1};
            // A zero-amount shift completes here with the source unchanged.
            c_SLL:  begin alu_out = {1'b0, arg0}; dir = SH_LL; end
            c_SRL:  begin alu_out = {1'b0, arg0}; dir = SH_RL; end
            c_SRA:  begin alu_out = {1'b0, arg0}; dir = SH_RA; end
            default: ;
        endcase
    end

    alu1_shifter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && long_shift),
        .data_in   (arg0),
        .shamt     (shamt),
        .dir       (dir),
        .data_next (sh_next),
        .last      (sh_last),
        .done      (sh_done)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = long_shift ? SHIFT : DONE;
            SHIFT:   if (sh_last || sh_done) state_next = DONE;
            DONE:    if (clear) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            res     <= '0;
            o_rd    <= '0;
            o_error <= 1'b0;
            i_error <= 1'b0;
        end else begin
            state   <= state_next;
            i_error <= (state == IDLE) && start && !supported;
            unique case (state)
                IDLE: if (accept) begin
                    o_rd <= i_rd;
                    if (!long_shift) begin
                        res     <= alu_out[XLEN-1:0];
                        o_error <= alu_out[XLEN];
                    end
                end
                SHIFT: if (sh_last || sh_done) res <= sh_next;
                DONE: if (clear) begin
                    res     <= '0;
                    o_rd    <= '0;
                    o_error <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign valid = (state == DONE);

endmodule

// File: tb/tb_alu1.sv
// Scoreboard bench for alu1: two instances (SHIFT_STEP 1 and 4) share stimulus,
// expected results are queued at issue and popped when each valid rises.
module tb_alu1;
    import core_config_pkg::*;

    logic          clk = 1'b0;
    logic          rst, start, clear;
    alu_commands_t cmd;
    logic [31:0]   arg0, arg1;
    logic [4:0]    i_rd;

    logic        busy1, valid1, oerr1, ierr1;
    logic [31:0] res1;
    logic [4:0]  ord1;
    logic        busy4, valid4, oerr4, ierr4;
    logic [31:0] res4;
    logic [4:0]  ord4;

    always #5 clk = ~clk;

    alu1 #(.XLEN(32), .REG_ADDR_W(5), .SHIFT_STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .arg0(arg0), .arg1(arg1),
        .i_rd(i_rd), .busy(busy1), .valid(valid1), .res(res1), .o_rd(ord1),
        .o_error(oerr1), .i_error(ierr1), .clear(clear));

    alu1 #(.XLEN(32), .REG_ADDR_W(5), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .arg0(arg0), .arg1(arg1),
        .i_rd(i_rd), .busy(busy4), .valid(valid4), .res(res4), .o_rd(ord4),
        .o_error(oerr4), .i_error(ierr4), .clear(clear));

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        err;
        int          lat1;
        int          lat4;
        int          issue;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int total = 0, bad = 0, cyc = 0, pushed = 0, got1 = 0, got4 = 0;
    logic v1_prev = 1'b0, v4_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (valid1 && !v1_prev) begin
            if (q1.size() == 0) fail_now("unexpected result step1");
            else begin
                e = q1.pop_front();
                chk("res step1", res1, e.res);
                chk("o_rd step1", ord1, e.rd);
                chk("o_error step1", oerr1, e.err);
                chk("latency step1", cyc - e.issue, e.lat1);
                got1++;
            end
        end
        v1_prev <= valid1;
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (valid4 && !v4_prev) begin
            if (q4.size() == 0) fail_now("unexpected result step4");
            else begin
                e = q4.pop_front();
                chk("res step4", res4, e.res);
                chk("o_rd step4", ord4, e.rd);
                chk("o_error step4", oerr4, e.err);
                chk("latency step4", cyc - e.issue, e.lat4);
                got4++;
            end
        end
        v4_prev <= valid4;
    end

    // All tasks start and end just after a falling edge.
    task automatic issue(input alu_commands_t c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] r, input logic er,
                         input int l1, input int l4);
        exp_t e;
        cmd = c; arg0 = a; arg1 = b; i_rd = rd; start = 1'b1;
        e = '{res: r, rd: rd, err: er, lat1: l1, lat4: l4, issue: cyc};
        q1.push_back(e);
        q4.push_back(e);
        pushed++;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_both();
        int n = 0;
        while (!(valid1 && valid4) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("timeout waiting for valid");
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("valid after clear", {valid1, valid4}, 2'b00);
        chk("busy after clear", {busy1, busy4}, 2'b00);
        chk("res after clear", {res1, res4}, 64'h0);
        chk("o_rd/o_error after clear", {ord1, ord4, oerr1, oerr4}, 12'h0);
    endtask

    task automatic run(input alu_commands_t c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] r, input logic er,
                       input int l1, input int l4);
        issue(c, a, b, rd, r, er, l1, l4);
        wait_both();
        do_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0; cmd = c_ADD;
        arg0 = '0; arg1 = '0; i_rd = '0;
        repeat (2) @(negedge clk);
        chk("reset busy/valid", {busy1, valid1, busy4, valid4}, 4'b0);
        chk("reset res", {res1, res4}, 64'h0);
        chk("reset rd/err/ierr", {ord1, oerr1, ierr1, ord4, oerr4, ierr4}, 14'h0);
        rst = 1'b0;
        @(negedge clk);

        // ADD carry-out, result held over idle cycles until clear
        issue(c_ADD, 32'hFFFF_FFFF, 32'h1, 5'd1, 32'h0, 1'b1, 1, 1);
        wait_both();
        repeat (3) @(negedge clk);
        chk("held valid", {valid1, valid4, busy1, busy4}, 4'b1111);
        chk("held res", {res1, res4}, 64'h0);
        chk("held o_error/o_rd", {oerr1, ord1, oerr4, ord4}, {1'b1, 5'd1, 1'b1, 5'd1});
        do_clear();

        run(c_SUB,  32'd5,         32'd7,         5'd2,  32'hFFFF_FFFE, 1'b1, 1, 1);
        run(c_SLT,  32'h8000_0000, 32'd1,         5'd3,  32'h1,         1'b0, 1, 1);
        run(c_SLTU, 32'h8000_0000, 32'd1,         5'd4,  32'h0,         1'b0, 1, 1);
        run(c_AND,  32'h0000_F0F0, 32'h0000_FF00, 5'd5,  32'h0000_F000, 1'b0, 1, 1);
        run(c_OR,   32'h0000_F0F0, 32'h0000_FF00, 5'd6,  32'h0000_FFF0, 1'b0, 1, 1);
        run(c_XOR,  32'h0000_F0F0, 32'h0000_FF00, 5'd7,  32'h0000_0FF0, 1'b0, 1, 1);
        run(c_SRA,  32'h8000_0000, 32'd31,        5'd8,  32'hFFFF_FFFF, 1'b0, 32, 9);
        run(c_SLL,  32'h0000_1234, 32'h20,        5'd9,  32'h0000_1234, 1'b0, 1, 1);
        run(c_SRL,  32'h0000_00F0, 32'd4,         5'd10, 32'h0000_000F, 1'b0, 5, 2);
        run(c_SLL,  32'h0000_0001, 32'd5,         5'd11, 32'h0000_0020, 1'b0, 6, 3);

        // unsupported command: single-cycle i_error, no result
        cmd = alu_commands_t'(4'hF); arg0 = 32'h1; arg1 = 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("i_error pulse", {ierr1, ierr4}, 2'b11);
        chk("illegal no valid/busy", {valid1, valid4, busy1, busy4}, 4'b0);
        @(negedge clk);
        chk("i_error one cycle", {ierr1, ierr4}, 2'b00);

        // second start during a shift is ignored
        issue(c_SRL, 32'h8000_0000, 32'd8, 5'd12, 32'h0080_0000, 1'b0, 9, 3);
        cmd = c_ADD; arg0 = 32'h1; arg1 = 32'h1; i_rd = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("no i_error while busy", {ierr1, ierr4}, 2'b00);
        wait_both();
        do_clear();

        // reset in the third cycle of a 10-bit shift drops the pending result
        cmd = c_SLL; arg0 = 32'h1; arg1 = 32'd10; i_rd = 5'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst mid-shift busy/valid", {busy1, valid1, busy4, valid4}, 4'b0);
        chk("rst mid-shift res", {res1, res4}, 64'h0);
        chk("rst mid-shift rd/err", {ord1, oerr1, ord4, oerr4}, 12'h0);

        run(c_ADD, 32'd2, 32'd3, 5'd14, 32'd5, 1'b0, 1, 1);

        repeat (2) @(negedge clk);
        chk("scoreboard drained step1", q1.size(), 0);
        chk("scoreboard drained step4", q4.size(), 0);
        chk("results seen step1", got1, pushed);
        chk("results seen step4", got4, pushed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
